// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection controller and its tick source and lamp drivers.
// master drives the tick/request side; slave is the controller itself.
interface traffic_light_ctrl_if;
    logic       tick;
    logic       ped_req;
    logic       ns_g;
    logic       ns_y;
    logic       ns_r;
    logic       ew_g;
    logic       ew_y;
    logic       ew_r;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output tick, ped_req,
        input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending, phase
    );

    modport slave (
        input  tick, ped_req,
        output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending, phase
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection light sequencer with parametrised phase lengths and all-red clearance.
// Define TL_PED_EN to build the latched pedestrian walk phase.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 4,
    parameter int unsigned CNT_W        = 8
) (
    input logic                  clk,
    input logic                  rst,
    traffic_light_ctrl_if.slave  tl
);

    typedef enum logic [2:0] {
        StNsG  = 3'd0,
        StNsY  = 3'd1,
        StArA  = 3'd2,
        StEwG  = 3'd3,
        StEwY  = 3'd4,
        StArB  = 3'd5,
        StWalk = 3'd6
    } state_e;

    localparam bit             HasAllRed  = (ALLRED_TICKS != 0);
    localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(HasAllRed ? ALLRED_TICKS - 1 : 0);
    localparam logic [CNT_W-1:0] WalkLast   = CNT_W'(WALK_TICKS - 1);

    // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    localparam logic [6:0] LampsNsG  = 7'b1000010;
    localparam logic [6:0] LampsNsY  = 7'b0100010;
    localparam logic [6:0] LampsEwG  = 7'b0011000;
    localparam logic [6:0] LampsEwY  = 7'b0010100;
    localparam logic [6:0] LampsRed  = 7'b0010010;
    localparam logic [6:0] LampsWalk = 7'b0010011;

    state_e             state_q, state_d, state_nxt, cycle_end;
    logic [CNT_W-1:0]   count_q, count_d, last;
    logic               ped_q, ped_d;
    logic [6:0]         lamps_q, lamps_d;
    logic               valid;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        last      = '0;
        state_nxt = StNsG;
        valid     = 1'b1;
`ifdef TL_PED_EN
        cycle_end = ped_q ? StWalk : StNsG;
`else
        cycle_end = StNsG;
`endif

        case (state_q)
            StNsG: begin last = GreenLast;  state_nxt = StNsY;                      end
            StNsY: begin last = YellowLast; state_nxt = HasAllRed ? StArA : StEwG;  end
            StArA: begin last = AllRedLast; state_nxt = StEwG;                      end
            StEwG: begin last = GreenLast;  state_nxt = StEwY;                      end
            StEwY: begin last = YellowLast; state_nxt = HasAllRed ? StArB : cycle_end; end
            StArB: begin last = AllRedLast; state_nxt = cycle_end;                  end
`ifdef TL_PED_EN
            StWalk: begin last = WalkLast;  state_nxt = StNsG;                      end
`endif
            default: valid = 1'b0;
        endcase

        // Unreachable codes recover to NS_G regardless of tick.
        if (!valid) begin
            state_d = StNsG;
            count_d = '0;
        end else if (tl.tick) begin
            if (count_q == last) begin
                state_d = state_nxt;
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

`ifdef TL_PED_EN
        // Entering WALK clears the latch even if a request arrives the same cycle.
        if (state_d == StWalk && state_q != StWalk) begin
            ped_d = 1'b0;
        end else if (tl.ped_req && state_q != StWalk) begin
            ped_d = 1'b1;
        end else begin
            ped_d = ped_q;
        end
`else
        ped_d = 1'b0;
`endif

        case (state_d)
            StNsG:   lamps_d = LampsNsG;
            StNsY:   lamps_d = LampsNsY;
            StEwG:   lamps_d = LampsEwG;
            StEwY:   lamps_d = LampsEwY;
            StWalk:  lamps_d = LampsWalk;
            default: lamps_d = LampsRed;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StNsG;
            count_q <= '0;
            ped_q   <= 1'b0;
            lamps_q <= LampsNsG;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ped_q   <= ped_d;
            lamps_q <= lamps_d;
        end
    end

`ifndef TL_PED_EN
    logic unused_ped_req;
    assign unused_ped_req = tl.ped_req;
`endif

    assign tl.ns_g        = lamps_q[6];
    assign tl.ns_y        = lamps_q[5];
    assign tl.ns_r        = lamps_q[4];
    assign tl.ew_g        = lamps_q[3];
    assign tl.ew_y        = lamps_q[2];
    assign tl.ew_r        = lamps_q[1];
    assign tl.walk        = lamps_q[0];
    assign tl.ped_pending = ped_q;
    assign tl.phase       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a default instance and a no-all-red short-phase instance share
// stimulus and are checked every cycle against a phase-list reference model.
module tb_traffic_light_ctrl;

`ifdef TL_PED_EN
    localparam bit PedEn = 1'b1;
`else
    localparam bit PedEn = 1'b0;
`endif

    logic clk;
    logic rst;
    logic tick;
    logic ped_req;

    int checks = 0;
    int errors = 0;

    traffic_light_ctrl_if tl0 ();
    traffic_light_ctrl_if tl1 ();

    assign tl0.tick    = tick;
    assign tl0.ped_req = ped_req;
    assign tl1.tick    = tick;
    assign tl1.ped_req = ped_req;

    traffic_light_ctrl u_dut0 (
        .clk (clk),
        .rst (rst),
        .tl  (tl0)
    );

    traffic_light_ctrl #(
        .GREEN_TICKS  (3),
        .YELLOW_TICKS (1),
        .ALLRED_TICKS (0),
        .WALK_TICKS   (4),
        .CNT_W        (8)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .tl  (tl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each instance walks a list of road phases; WALK is appended at the end
    // of the list when a request is pending.
    int         dur    [2][7];
    int         seq    [2][6];
    int         nseq   [2];
    int         m_idx  [2];
    int         m_left [2];
    bit         m_walk [2];
    bit         m_ped  [2];
    logic [7:0] lamp_tab [7];

    function automatic int cur_phase(input int i);
        return m_walk[i] ? 6 : seq[i][m_idx[i]];
    endfunction

    task automatic model_step(input logic t, input logic p, input logic r);
        for (int i = 0; i < 2; i++) begin
            int  cur;
            bit  enter;
            if (r) begin
                m_idx[i]  = 0;
                m_walk[i] = 1'b0;
                m_ped[i]  = 1'b0;
                m_left[i] = dur[i][0];
            end else begin
                cur   = cur_phase(i);
                enter = 1'b0;
                if (t) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        if (m_walk[i]) begin
                            m_walk[i] = 1'b0;
                            m_idx[i]  = 0;
                        end else if (m_idx[i] == nseq[i] - 1) begin
                            if (PedEn && m_ped[i]) begin
                                m_walk[i] = 1'b1;
                                enter     = 1'b1;
                            end else begin
                                m_idx[i] = 0;
                            end
                        end else begin
                            m_idx[i]++;
                        end
                        m_left[i] = dur[i][cur_phase(i)];
                    end
                end
                if (PedEn) begin
                    if (enter) m_ped[i] = 1'b0;
                    else if (p && cur != 6) m_ped[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("phase0", {5'b0, tl0.phase}, 8'(cur_phase(0)));
        chk("lamps0", {1'b0, tl0.ns_g, tl0.ns_y, tl0.ns_r, tl0.ew_g, tl0.ew_y, tl0.ew_r, tl0.walk},
            lamp_tab[cur_phase(0)]);
        chk("pend0", {7'b0, tl0.ped_pending}, {7'b0, m_ped[0]});
        chk("phase1", {5'b0, tl1.phase}, 8'(cur_phase(1)));
        chk("lamps1", {1'b0, tl1.ns_g, tl1.ns_y, tl1.ns_r, tl1.ew_g, tl1.ew_y, tl1.ew_r, tl1.walk},
            lamp_tab[cur_phase(1)]);
        chk("pend1", {7'b0, tl1.ped_pending}, {7'b0, m_ped[1]});
        chk("onehot_ns1", {7'b0, $countones({tl1.ns_g, tl1.ns_y, tl1.ns_r}) == 1}, 8'd1);
        chk("onehot_ew1", {7'b0, $countones({tl1.ew_g, tl1.ew_y, tl1.ew_r}) == 1}, 8'd1);
        chk("no_allred1", {7'b0, (tl1.phase == 3'd2) || (tl1.phase == 3'd5)}, 8'd0);
    endtask

    task automatic do_cycle(input logic t, input logic p, input logic r);
        tick    = t;
        ped_req = p;
        rst     = r;
        @(posedge clk);
        model_step(t, p, r);
        @(negedge clk);
        check_all();
    endtask

    int exp_seq [17];
    int ns_cnt;
    bit ns_done;

    initial begin
        dur[0] = '{5, 2, 1, 5, 2, 1, 4};
        dur[1] = '{3, 1, 1, 3, 1, 1, 4};
        seq[0] = '{0, 1, 2, 3, 4, 5};
        seq[1] = '{0, 1, 3, 4, 0, 0};
        nseq   = '{6, 4};
        lamp_tab = '{8'b01000010, 8'b00100010, 8'b00010010, 8'b00011000,
                     8'b00010100, 8'b00010010, 8'b00010011};
        exp_seq = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 4, 4, 5, 0, 0};

        tick    = 1'b0;
        ped_req = 1'b0;
        rst     = 1'b1;
        @(negedge clk);

        // Reset state
        do_cycle(1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b1, 1'b1);
        chk("rst_phase", {5'b0, tl0.phase}, 8'd0);
        chk("rst_ns_g", {7'b0, tl0.ns_g}, 8'd1);
        chk("rst_ew_r", {7'b0, tl0.ew_r}, 8'd1);
        chk("rst_pend", {7'b0, tl0.ped_pending}, 8'd0);

        // Tick held high, no request: 16-cycle sequence
        for (int k = 0; k < 17; k++) begin
            do_cycle(1'b1, 1'b0, 1'b0);
            chk($sformatf("seq_%0d", k), {5'b0, tl0.phase}, 8'(exp_seq[k]));
        end

        // Tick every 4th cycle: NS_G spans 20 clocks
        do_cycle(1'b0, 1'b0, 1'b1);
        ns_cnt  = 1;
        ns_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            do_cycle((i % 4) == 3, 1'b0, 1'b0);
            if (!ns_done && tl0.ns_g) ns_cnt++;
            else ns_done = 1'b1;
        end
        chk("ns_g_len", 8'(ns_cnt), 8'd20);

        // Reset mid EW_Y with tick and request high
        do_cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 13; k++) do_cycle(1'b1, 1'b0, 1'b0);
        chk("pre_rst_ewy", {5'b0, tl0.phase}, 8'd4);
        do_cycle(1'b1, 1'b1, 1'b1);
        chk("midrst_phase", {5'b0, tl0.phase}, 8'd0);
        chk("midrst_ns_g", {7'b0, tl0.ns_g}, 8'd1);
        chk("midrst_pend", {7'b0, tl0.ped_pending}, 8'd0);

        // Single request pulse during EW_G
        do_cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b1, 1'b0);
        chk("pulse_pend", {7'b0, tl0.ped_pending}, {7'b0, PedEn});
        for (int k = 0; k < 30; k++) do_cycle(1'b1, 1'b0, 1'b0);

        // Request held high with tick high
        do_cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 45; k++) do_cycle(1'b1, 1'b1, 1'b0);

        // Randomized ticks, requests and occasional resets
        for (int k = 0; k < 800; k++) begin
            do_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
